truth_table_extractor: RTL and testbench
========================================

# truth_table_extractor

Characterisation block that recovers the 3-input truth table of a combinational logic gate under test. It drives all eight input combinations onto the gate in a fixed order, waits a programmable settle time, samples the gate output twice, and assembles the result into the same 8-bit hex encoding the codebase uses to name its 3-input functions. It sits on the test/characterisation side, facing any 3-input one-output module from the gate library.

## Interface

- SETTLE_CYCLES, default 4, cycles the inputs are held before the first sample; legal range 1..255.

- clk  input  1  sole clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request a sweep; honoured only in IDLE
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse when the table is complete
- tt_out  output  8  extracted truth table; held until the next accepted start or reset
- tt_valid  output  1  high from done until the next accepted start or reset
- unstable  output  1  sticky per sweep; set if any row's two samples differed
- dut_in1  output  1  gate input 1, MSB of the row index
- dut_in2  output  1  gate input 2
- dut_in3  output  1  gate input 3, LSB of the row index
- dut_out  input  1  gate output, same clock domain, combinational from dut_in*

## Operation

- States: IDLE, APPLY, SAMPLE, DONE.
- IDLE: dut_in = 000, busy = 0. If start is high: row := 0, settle counter := 0, tt_out := 0x00, tt_valid := 0, unstable := 0, go to APPLY.
- APPLY: dut_in = row. The counter increments each cycle. In the cycle where counter == SETTLE_CYCLES-1, capture s0 := dut_out and go to SAMPLE.
- SAMPLE: capture s1 := dut_out. Write tt_out[7-row] := s1. If s0 != s1, set unstable.
  - If row == 7, go to DONE.
  - Otherwise row := row+1, counter := 0, go to APPLY.
- DONE: pulse done for one cycle, set tt_valid, busy := 0, dut_in := 000, go to IDLE.
- Bit order: row index r = {in1,in2,in3} maps to tt_out bit 7-r. Row 000 is the MSB and row 111 is the LSB. Example: a gate with outputs 1,0,1,0,0,1,1,0 for rows 000..111 yields 0xA6.
- start while busy: ignored, no effect.
- start in the DONE cycle: ignored. It is accepted from the following IDLE cycle.
- The row counter does not wrap. The sweep ends at row 7.

## Timing

- Reset values: busy=0, done=0, tt_out=0x00, tt_valid=0, unstable=0, dut_in=000, state IDLE.
- Reset mid-sweep: all of the above apply immediately (asynchronous) and the sweep is aborted. No done pulse is generated.
- start sampled high at edge k: busy and dut_in = 000 (row 0) are valid after edge k.
- Per row: SETTLE_CYCLES APPLY cycles plus 1 SAMPLE cycle.
- done is high in cycle k + 8*(SETTLE_CYCLES+1) + 1 after the accepting edge. For the default setting: 41 cycles after start.
- tt_out bits update progressively during the sweep. They are meaningful only while tt_valid is high.
- dut_in changes only on the edge entering APPLY for a new row, or on the edge entering IDLE/DONE.

## Structure

- Shared package tt_pkg holds:
  - the state enum
  - the constant NUM_ROWS = 8
  - a function row_to_bit(r) = 7-r, reused by any future 2-input or 4-input variant
- Sub-module settle_timer: holds the SETTLE_CYCLES counter with clear/enable inputs and an expire output.
- Everything else stays in the top module.

## Test plan

- Gate model with rows 1,0,1,0,0,1,1,0; start pulse → done 41 cycles later, tt_out = 0xA6, tt_valid = 1, unstable = 0.
- Constant-1 gate, SETTLE_CYCLES = 1 → tt_out = 0xFF after 17 cycles; constant-0 gate → tt_out = 0x00.
- Gate whose output toggles every cycle only while the row is 011 → unstable = 1. The other seven bits match the model, and tt_out[4] equals the second sample.
- Assert rst in the 20th busy cycle → all outputs return to reset values that same cycle and no done pulse occurs. A new start then gives the correct table.
- Pulse start repeatedly while busy → a single sweep, done pulses exactly once. start in the DONE cycle is ignored. start one cycle later begins a new sweep, with tt_valid dropping and tt_out = 0x00.

Source files
------------

// File: rtl/tt_pkg.sv
// tt_pkg: shared state encoding, row count and row-to-bit mapping for truth table extraction
package tt_pkg;
  typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, DONE} state_t;
  localparam int NUM_ROWS = 8;
  function automatic logic [2:0] row_to_bit(input logic [2:0] r);
    return 3'(NUM_ROWS - 1 - int'(r));
  endfunction
endpackage

// File: rtl/settle_timer.sv
// settle_timer: counts hold cycles for the applied row and flags the final one
module settle_timer #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  logic [7:0] cnt_q, cnt_d;
  // clear has priority so a new row always starts from zero
  always_comb cnt_d = clr ? 8'd0 : en ? cnt_q + 8'd1 : cnt_q;
  // counter register
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= 8'd0;
    else cnt_q <= cnt_d;
  assign expire = en && (cnt_q == 8'(SETTLE_CYCLES - 1));
endmodule

// File: rtl/truth_table_extractor.sv
// truth_table_extractor: sweeps all 3-input rows through a gate and assembles its 8-bit truth table
module truth_table_extractor
  import tt_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [7:0] tt_out,
  output logic       tt_valid,
  output logic       unstable,
  output logic       dut_in1,
  output logic       dut_in2,
  output logic       dut_in3,
  input  logic       dut_out
);
  state_t     state_q, state_d;
  logic [2:0] row_q, row_d;
  logic [7:0] tt_q, tt_d;
  logic       s0_q, s0_d, valid_q, valid_d, unstable_q, unstable_d, expire;
  settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
    .clk(clk),
    .rst(rst),
    .clr(state_q != APPLY),
    .en(state_q == APPLY),
    .expire(expire)
  );
  // sweep sequencing: settle, double-sample, record bit, advance row
  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    tt_d       = tt_q;
    s0_d       = s0_q;
    valid_d    = valid_q;
    unstable_d = unstable_q;
    case (state_q)
      IDLE: if (start) begin
        row_d      = 3'd0;
        tt_d       = 8'h00;
        valid_d    = 1'b0;
        unstable_d = 1'b0;
        state_d    = APPLY;
      end
      APPLY: if (expire) begin
        s0_d    = dut_out;
        state_d = SAMPLE;
      end
      SAMPLE: begin
        tt_d[row_to_bit(row_q)] = dut_out;
        unstable_d = unstable_q | (s0_q != dut_out);
        valid_d    = row_q == 3'(NUM_ROWS - 1);
        state_d    = valid_d ? DONE : APPLY;
        row_d      = valid_d ? row_q : row_q + 3'd1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // state and result registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q    <= IDLE;
      row_q      <= 3'd0;
      tt_q       <= 8'h00;
      s0_q       <= 1'b0;
      valid_q    <= 1'b0;
      unstable_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      tt_q       <= tt_d;
      s0_q       <= s0_d;
      valid_q    <= valid_d;
      unstable_q <= unstable_d;
    end
  assign busy     = (state_q == APPLY) || (state_q == SAMPLE);
  assign done     = state_q == DONE;
  assign tt_out   = tt_q;
  assign tt_valid = valid_q;
  assign unstable = unstable_q;
  assign {dut_in1, dut_in2, dut_in3} = busy ? row_q : 3'd0;
endmodule

// File: tb/tb_truth_table_extractor.sv
// tb_truth_table_extractor: random gate sweeps on two settle settings checked against a timing-level model
module tb_truth_table_extractor;
  logic       clk = 0, rst = 1, tog = 0;
  logic       start_v [2], busy_v [2], done_v [2], valid_v [2], uns_v [2];
  logic       in1_v [2], in2_v [2], in3_v [2], out_v [2], glitch_v [2];
  logic [7:0] tt_v [2], gate_tt [2];
  int         checks = 0, errors = 0;
  always #5 clk = ~clk;
  always @(posedge clk) tog <= ~tog;
  truth_table_extractor #(.SETTLE_CYCLES(4)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .tt_out(tt_v[0]), .tt_valid(valid_v[0]), .unstable(uns_v[0]),
    .dut_in1(in1_v[0]), .dut_in2(in2_v[0]), .dut_in3(in3_v[0]), .dut_out(out_v[0])
  );
  truth_table_extractor #(.SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .tt_out(tt_v[1]), .tt_valid(valid_v[1]), .unstable(uns_v[1]),
    .dut_in1(in1_v[1]), .dut_in2(in2_v[1]), .dut_in3(in3_v[1]), .dut_out(out_v[1])
  );
  for (genvar g = 0; g < 2; g++) begin : gate
    assign out_v[g] = (glitch_v[g] && {in1_v[g], in2_v[g], in3_v[g]} == 3'd3) ? tog
                    : gate_tt[g][3'd7 - {in1_v[g], in2_v[g], in3_v[g]}];
  end
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_reset(input int i);
    check("rst_busy", busy_v[i], 0);
    check("rst_done", done_v[i], 0);
    check("rst_tt", tt_v[i], 8'h00);
    check("rst_valid", valid_v[i], 0);
    check("rst_uns", uns_v[i], 0);
    check("rst_din", {in1_v[i], in2_v[i], in3_v[i]}, 0);
  endtask
  task automatic sweep(input int i, input logic [7:0] g, input bit gl, input bit spam);
    int         s, last, r, ph;
    logic       s0 [8], s1 [8];
    logic [7:0] exp;
    bit         uns;
    s = (i == 0) ? 4 : 1;
    last = 8 * (s + 1);
    gate_tt[i] = g;
    glitch_v[i] = gl;
    @(negedge clk);
    start_v[i] = 1;
    @(posedge clk);
    #1 start_v[i] = 0;
    for (int n = 1; n <= last + 1; n++) begin
      @(negedge clk);
      if (n <= last) begin
        r = (n - 1) / (s + 1);
        ph = (n - 1) % (s + 1);
        check("busy", busy_v[i], 1);
        check("done_early", done_v[i], 0);
        check("din", {in1_v[i], in2_v[i], in3_v[i]}, 8'(r));
        if (n == 1) begin
          check("clr_valid", valid_v[i], 0);
          check("clr_tt", tt_v[i], 8'h00);
          check("clr_uns", uns_v[i], 0);
        end
        if (ph == s - 1) s0[r] = out_v[i];
        if (ph == s) s1[r] = out_v[i];
        start_v[i] = spam ? 1'($urandom) : 1'b0;
      end else begin
        uns = 0;
        for (int k = 0; k < 8; k++) begin
          exp[7 - k] = s1[k];
          uns |= s0[k] != s1[k];
        end
        check("done", done_v[i], 1);
        check("busy_done", busy_v[i], 0);
        check("valid", valid_v[i], 1);
        check("tt", tt_v[i], exp);
        check("uns", uns_v[i], 8'(uns));
        check("din_done", {in1_v[i], in2_v[i], in3_v[i]}, 0);
        start_v[i] = spam;
      end
    end
    @(negedge clk);
    check("done_once", done_v[i], 0);
    check("busy_idle", busy_v[i], 0);
    check("valid_hold", valid_v[i], 1);
    check("tt_hold", tt_v[i], exp);
    if (spam) begin
      @(negedge clk);
      check("restart_busy", busy_v[i], 1);
      check("restart_valid", valid_v[i], 0);
      check("restart_tt", tt_v[i], 8'h00);
      start_v[i] = 0;
      rst = 1;
      @(negedge clk);
      rst = 0;
    end
  endtask
  initial begin
    bit         seen;
    logic [7:0] g;
    start_v = '{0, 0};
    glitch_v = '{0, 0};
    gate_tt = '{8'h00, 8'h00};
    repeat (3) @(negedge clk);
    check_reset(0);
    check_reset(1);
    rst = 0;
    sweep(0, 8'hA6, 0, 0);
    check("gate_a6", tt_v[0], 8'hA6);
    check("gate_a6_uns", uns_v[0], 0);
    sweep(1, 8'hFF, 0, 0);
    check("const1", tt_v[1], 8'hFF);
    sweep(1, 8'h00, 0, 0);
    check("const0", tt_v[1], 8'h00);
    g = 8'($urandom);
    sweep(0, g, 1, 0);
    check("glitch_uns", uns_v[0], 1);
    check("glitch_rest", tt_v[0] & 8'hEF, g & 8'hEF);
    gate_tt[0] = 8'h5C;
    glitch_v[0] = 0;
    @(negedge clk);
    start_v[0] = 1;
    @(posedge clk);
    #1 start_v[0] = 0;
    repeat (20) @(negedge clk);
    check("pre_rst_busy", busy_v[0], 1);
    rst = 1;
    #1 check_reset(0);
    @(negedge clk);
    rst = 0;
    seen = 0;
    repeat (60) begin
      @(negedge clk);
      seen |= done_v[0];
    end
    check("no_done_after_rst", 8'(seen), 0);
    sweep(0, 8'h5C, 0, 0);
    check("after_rst_tt", tt_v[0], 8'h5C);
    sweep(0, 8'($urandom), 0, 1);
    repeat (8) begin
      automatic int i = int'($urandom_range(1));
      sweep(i, 8'($urandom), 1'($urandom), 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
